// File: rtl/timer_counter.sv
// Memory-mapped 32-bit down-counting timer with a CTRL/PRESET/COUNT word window
// and a maskable interrupt. Supports one-shot and auto-reload modes.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      r_state;
    logic [3:0]  r_ctrl;
    logic [31:0] r_preset;
    logic [31:0] r_count;
    logic        r_irq_flag;

    logic        w_sel;
    logic [1:0]  w_offset;
    logic        w_wr_ctrl;
    logic        w_wr_preset;
    logic        w_enable;
    logic [1:0]  w_mode;
    logic        w_fire;

    assign w_sel       = (Addr >= BASE_ADDR) && (Addr <= BASE_ADDR + 32'd11);
    assign w_offset    = Addr[3:2] - BASE_ADDR[3:2];
    assign w_wr_ctrl   = WE && w_sel && (w_offset == 2'd0);
    assign w_wr_preset = WE && w_sel && (w_offset == 2'd1);
    assign w_enable    = r_ctrl[0];
    assign w_mode      = r_ctrl[2:1];

    // Terminal count this edge; a same-cycle register write must not clear it.
    assign w_fire = (r_state == S_CNT) && w_enable && (r_count <= 32'd1);

    assign IRQ = r_irq_flag & r_ctrl[3];

    always_comb begin
        Dout = '0;
        if (w_sel) begin
            case (w_offset)
                2'd0:    Dout = {28'd0, r_ctrl};
                2'd1:    Dout = r_preset;
                2'd2:    Dout = r_count;
                default: Dout = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ctrl     <= '0;
            r_preset   <= '0;
            r_count    <= '0;
            r_irq_flag <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_enable) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_count <= r_preset;
                    r_state <= S_CNT;
                end
                S_CNT: begin
                    if (!w_enable) begin
                        r_state <= S_IDLE;
                    end else if (r_count > 32'd1) begin
                        r_count <= r_count - 32'd1;
                    end else begin
                        r_count    <= '0;
                        r_irq_flag <= 1'b1;
                        r_state    <= S_INT;
                    end
                end
                S_INT: begin
                    if (w_mode == 2'b01) begin
                        r_irq_flag <= 1'b0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_ctrl[0] <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Bus writes come last so a CTRL write overrides the one-shot Enable clear.
            if (w_wr_ctrl) begin
                r_ctrl <= Din[3:0];
            end
            if (w_wr_preset) begin
                r_preset <= Din;
            end
            if ((w_wr_ctrl || w_wr_preset) && !w_fire) begin
                r_irq_flag <= 1'b0;
            end
        end
    end

endmodule
